// File: rtl/mag_cmp_pkg.sv
// mag_cmp_pkg: shared types and elaboration helpers for the pipelined
// magnitude comparator.
//   cmp_res_t    : (gt, eq) result of one group or reduction node
//   GROUP_W      : bits per leaf slice
//   num_groups() : number of leaf slices for an operand width
//   num_levels() : ceil(log4(groups)), number of registered reduction levels
//   reduce4()    : one radix-4 reduction node, index 3 most significant
package mag_cmp_pkg;

   typedef struct packed {
      logic gt;
      logic eq;
   } cmp_res_t;

   localparam int unsigned GROUP_W = 4;

   // Neutral element of the reduction: never decides, never breaks equality.
   localparam cmp_res_t PAD_RES = '{gt: 1'b0, eq: 1'b1};

   function automatic int unsigned num_groups(input int unsigned width);
      return width / GROUP_W;
   endfunction

   function automatic int unsigned num_levels(input int unsigned groups);
      int unsigned n;
      int unsigned reach;
      n     = 0;
      reach = 1;
      for (int unsigned i = 0; i < 16; i++) begin
         if (reach < groups) begin
            reach = reach * 4;
            n     = n + 1;
         end
      end
      return n;
   endfunction

   function automatic cmp_res_t reduce4(input cmp_res_t [3:0] x);
      cmp_res_t r;
      r.gt = x[3].gt
           | (x[3].eq & x[2].gt)
           | (x[3].eq & x[2].eq & x[1].gt)
           | (x[3].eq & x[2].eq & x[1].eq & x[0].gt);
      r.eq = x[3].eq & x[2].eq & x[1].eq & x[0].eq;
      return r;
   endfunction

endpackage

// File: rtl/mag_cmp_pipe_cmp4_slice.sv
// cmp4_slice: combinational 4-bit magnitude comparator leaf.
//   a, b : 4-bit operand group
//   gt   : a > b, decided at the first differing bit from the top
//   eq   : all four bits equal
module cmp4_slice
   import mag_cmp_pkg::*;
(
   input  logic [GROUP_W-1:0] a,
   input  logic [GROUP_W-1:0] b,
   output logic               gt,
   output logic               eq
);

   logic decided;

   always_comb begin
      gt      = 1'b0;
      decided = 1'b0;
      for (int unsigned i = 0; i < GROUP_W; i++) begin
         if (!decided && (a[GROUP_W-1-i] != b[GROUP_W-1-i])) begin
            decided = 1'b1;
            gt      = a[GROUP_W-1-i];
         end
      end
   end

   assign eq = (a == b);

endmodule

// File: rtl/mag_cmp_pipe.sv
// mag_cmp_pipe: pipelined WIDTH-bit magnitude comparator behind a
// valid/ready handshake with a pass-through tag. Whole pipe stalls together.
//   clk, reset           : clock, synchronous active-high reset
//   in_valid/in_ready    : input handshake (in_ready = ~out_valid | out_ready)
//   a, b, in_tag         : operands and tag
//   signed_mode          : two's complement compare (only with MAG_CMP_SIGNED_EN)
//   out_valid/out_ready  : output handshake
//   gt, eq, lt, out_tag  : one-hot result flags and tag of presented result
// Optional feature macro: MAG_CMP_SIGNED_EN.
module mag_cmp_pipe
   import mag_cmp_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned TAG_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [TAG_W-1:0] in_tag,
`ifdef MAG_CMP_SIGNED_EN
   input  logic             signed_mode,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic             gt,
   output logic             eq,
   output logic             lt,
   output logic [TAG_W-1:0] out_tag
);

   localparam int unsigned G      = num_groups(WIDTH);
   localparam int unsigned LEVELS = num_levels(G);

   // Node count of tree level k (level 0 = registered slice outputs).
   function automatic int unsigned lvl_cnt(input int unsigned k);
      int unsigned n;
      n = G;
      for (int unsigned i = 0; i < k; i++) begin
         n = (n + 3) / 4;
      end
      return n;
   endfunction

   // Position of level k inside the flat tree register.
   function automatic int unsigned lvl_off(input int unsigned k);
      int unsigned o;
      o = 0;
      for (int unsigned i = 0; i < k; i++) begin
         o = o + lvl_cnt(i);
      end
      return o;
   endfunction

   localparam int unsigned TOTAL = lvl_off(LEVELS) + 1;

   logic                          adv;
   logic [WIDTH-1:0]              a_cmp;
   logic [WIDTH-1:0]              b_cmp;
   logic [G-1:0]                  s_gt;
   logic [G-1:0]                  s_eq;
   cmp_res_t [TOTAL-1:0]          tree_q;
   cmp_res_t [TOTAL-1:0]          tree_d;
   cmp_res_t [3:0]                quad;
   int unsigned                   nchild;
   logic [LEVELS:0]               valid_q;
   logic [LEVELS:0][TAG_W-1:0]    tag_q;

`ifdef MAG_CMP_SIGNED_EN
   // Flipping the sign bits maps two's complement order onto unsigned order.
   always_comb begin
      a_cmp          = a;
      b_cmp          = b;
      a_cmp[WIDTH-1] = a[WIDTH-1] ^ signed_mode;
      b_cmp[WIDTH-1] = b[WIDTH-1] ^ signed_mode;
   end
`else
   assign a_cmp = a;
   assign b_cmp = b;
`endif

   for (genvar g = 0; g < G; g++) begin : g_slice
      cmp4_slice u_slice (
         .a  (a_cmp[GROUP_W*g +: GROUP_W]),
         .b  (b_cmp[GROUP_W*g +: GROUP_W]),
         .gt (s_gt[g]),
         .eq (s_eq[g])
      );
   end

   // Level k node j reduces children 4j..4j+3 of level k-1. A short last
   // node puts its real children in the upper slots and pads the bottom.
   always_comb begin
      tree_d = '0;
      quad   = '0;
      nchild = 0;
      for (int unsigned g = 0; g < G; g++) begin
         tree_d[g].gt = s_gt[g];
         tree_d[g].eq = s_eq[g];
      end
      for (int unsigned k = 1; k <= LEVELS; k++) begin
         for (int unsigned j = 0; j < lvl_cnt(k); j++) begin
            nchild = lvl_cnt(k-1) - 4*j;
            if (nchild > 4) begin
               nchild = 4;
            end
            for (int unsigned p = 0; p < 4; p++) begin
               if (p >= 4 - nchild) begin
                  quad[p] = tree_q[lvl_off(k-1) + 4*j + p - (4 - nchild)];
               end else begin
                  quad[p] = PAD_RES;
               end
            end
            tree_d[lvl_off(k) + j] = reduce4(quad);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         tag_q   <= '0;
         tree_q  <= '0;
      end else if (adv) begin
         tree_q     <= tree_d;
         valid_q[0] <= in_valid;
         tag_q[0]   <= in_tag;
         for (int unsigned s = 1; s <= LEVELS; s++) begin
            valid_q[s] <= valid_q[s-1];
            tag_q[s]   <= tag_q[s-1];
         end
      end
   end

   assign adv       = ~out_valid | out_ready;
   assign in_ready  = adv;
   assign out_valid = valid_q[LEVELS];
   assign out_tag   = tag_q[LEVELS];
   assign gt        = tree_q[TOTAL-1].gt;
   assign eq        = tree_q[TOTAL-1].eq;
   // Gated by valid so flags read all-zero out of reset.
   assign lt        = out_valid & ~tree_q[TOTAL-1].gt & ~tree_q[TOTAL-1].eq;

endmodule

// File: tb/tb_mag_cmp_pipe.sv
// tb_mag_cmp_pipe: four comparator instances (WIDTH 4, 16, 20, 64) driven by
// shared stimulus, each checked every cycle against a stall-aware delay-line
// model whose results come from plain integer comparison.
module tb_mag_cmp_pipe;

   localparam int unsigned WID [4] = '{4, 16, 20, 64};
   localparam int          LAT [4] = '{1, 2, 3, 3};
`ifdef MAG_CMP_SIGNED_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        out_ready;
   logic        sm;
   logic [63:0] a_all;
   logic [63:0] b_all;
   logic [3:0]  tag;
   logic        ir   [4];
   logic        ov   [4];
   logic        o_gt [4];
   logic        o_eq [4];
   logic        o_lt [4];
   logic [3:0]  ot   [4];

   int compared   = 0;
   int mismatched = 0;
   bit chk_en     = 1'b0;
   bit rx_en      = 1'b0;
   logic [3:0] rx_tags [$];

   // Model: per instance an L-deep delay line that only moves when the
   // output slot is empty or being taken.
   bit       mv   [4][3];
   bit [2:0] mres [4][3];
   bit [3:0] mtag [4][3];

   for (genvar d = 0; d < 4; d++) begin : g_dut
      mag_cmp_pipe #(.WIDTH(WID[d]), .TAG_W(4)) u_dut (
         .clk         (clk),
         .reset       (reset),
         .in_valid    (in_valid),
         .in_ready    (ir[d]),
         .a           (a_all[WID[d]-1:0]),
         .b           (b_all[WID[d]-1:0]),
         .in_tag      (tag),
`ifdef MAG_CMP_SIGNED_EN
         .signed_mode (sm),
`endif
         .out_valid   (ov[d]),
         .out_ready   (out_ready),
         .gt          (o_gt[d]),
         .eq          (o_eq[d]),
         .lt          (o_lt[d]),
         .out_tag     (ot[d])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {gt, eq, lt} of the low w bits, by integer comparison.
   function automatic bit [2:0] ref_cmp(input int unsigned w, input bit [63:0] x,
                                        input bit [63:0] y, input bit s);
      bit [63:0] sx;
      bit [63:0] sy;
      sx = x << (64 - w);
      sy = y << (64 - w);
      if (sx == sy) return 3'b010;
      if (s) return ($signed(sx) > $signed(sy)) ? 3'b100 : 3'b001;
      return (sx > sy) ? 3'b100 : 3'b001;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      for (int d = 0; d < 4; d++) begin
         if (reset) begin
            for (int s = 0; s < 3; s++) begin
               mv[d][s]   = 1'b0;
               mres[d][s] = 3'b000;
               mtag[d][s] = 4'd0;
            end
         end else if (!mv[d][LAT[d]-1] || out_ready) begin
            for (int s = LAT[d] - 1; s > 0; s--) begin
               mv[d][s]   = mv[d][s-1];
               mres[d][s] = mres[d][s-1];
               mtag[d][s] = mtag[d][s-1];
            end
            mv[d][0]   = in_valid;
            mres[d][0] = ref_cmp(WID[d], a_all, b_all, SIGNED_EN & sm);
            mtag[d][0] = tag;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int d = 0; d < 4; d++) begin
            bit ev;
            ev = mv[d][LAT[d]-1];
            chk($sformatf("w%0d_out_valid", WID[d]), 64'(ov[d]), 64'(ev));
            chk($sformatf("w%0d_in_ready", WID[d]), 64'(ir[d]), 64'(!ev || out_ready));
            if (ev) begin
               chk($sformatf("w%0d_flags", WID[d]), 64'({o_gt[d], o_eq[d], o_lt[d]}),
                   64'(mres[d][LAT[d]-1]));
               chk($sformatf("w%0d_tag", WID[d]), 64'(ot[d]), 64'(mtag[d][LAT[d]-1]));
               chk($sformatf("w%0d_onehot", WID[d]),
                   64'($countones({o_gt[d], o_eq[d], o_lt[d]})), 64'd1);
            end
         end
         if (rx_en && ov[1] && out_ready) rx_tags.push_back(ot[1]);
      end
   end

   // Single operand pair, out_ready held high; checks instance d after its latency.
   task automatic send1(input int d, input bit [63:0] x, input bit [63:0] y,
                        input bit s, input bit [3:0] t, input bit [2:0] exp);
      in_valid = 1'b1;
      a_all    = x;
      b_all    = y;
      sm       = s;
      tag      = t;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (LAT[d] - 1) @(posedge clk);
      @(negedge clk);
      chk($sformatf("dir_w%0d_valid_t%0d", WID[d], t), 64'(ov[d]), 64'd1);
      chk($sformatf("dir_w%0d_flags_t%0d", WID[d], t),
          64'({o_gt[d], o_eq[d], o_lt[d]}), 64'(exp));
      chk($sformatf("dir_w%0d_tag_t%0d", WID[d], t), 64'(ot[d]), 64'(t));
      @(posedge clk); #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      bit [3:0] pat;
      bit       acc;
      int       sent;
      int       cyc;

      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      sm        = 1'b0;
      a_all     = '0;
      b_all     = '0;
      tag       = '0;

      // Pin the reference model itself.
      chk("model_gt16", 64'(ref_cmp(16, 64'h1234, 64'h1233, 1'b0)), 64'b100);
      chk("model_sgn16", 64'(ref_cmp(16, 64'h8000, 64'h7FFF, 1'b1)), 64'b001);
      chk("model_pad20", 64'(ref_cmp(20, 64'h80000, 64'h7FFFF, 1'b0)), 64'b100);
      chk("model_eq4", 64'(ref_cmp(4, 64'h5, 64'hF5, 1'b0)), 64'b010);

      @(posedge clk); #1;
      chk_en = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_valid", 64'(ov[1]), 64'd0);
      chk("rst_flags", 64'({o_gt[1], o_eq[1], o_lt[1]}), 64'd0);
      chk("rst_tag", 64'(ot[1]), 64'd0);
      chk("rst_in_ready", 64'(ir[1]), 64'd1);
      @(posedge clk); #1;

      send1(1, 64'h1234, 64'h1233, 1'b0, 4'd3, 3'b100);
      send1(1, 64'hFFFF, 64'hFFFF, 1'b0, 4'd5, 3'b010);
      send1(1, 64'h8000, 64'h7FFF, 1'b0, 4'd6, 3'b100);
`ifdef MAG_CMP_SIGNED_EN
      send1(1, 64'h8000, 64'h7FFF, 1'b1, 4'd7, 3'b001);
`endif
      send1(2, 64'h80000, 64'h7FFFF, 1'b0, 4'd8, 3'b100);
      send1(2, 64'h00001, 64'h00002, 1'b0, 4'd9, 3'b001);

      // Reset with two comparisons in flight.
      in_valid = 1'b1;
      a_all    = 64'h10;
      b_all    = 64'h20;
      tag      = 4'd1;
      @(posedge clk); #1;
      a_all = 64'h30;
      tag   = 4'd2;
      @(posedge clk); #1;
      in_valid = 1'b0;
      reset    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_valid", 64'(ov[1]), 64'd0);
      chk("midrst_flags", 64'({o_gt[1], o_eq[1], o_lt[1]}), 64'd0);
      chk("midrst_tag", 64'(ot[1]), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
      end

      // Backpressure: tags 0..7 with out_ready cycling 1,0,0,1.
      pat  = 4'b1001;
      sent = 0;
      cyc  = 0;
      rx_tags.delete();
      rx_en = 1'b1;
      while (sent < 8 && cyc < 200) begin
         in_valid  = 1'b1;
         tag       = 4'(sent);
         a_all     = {$urandom, $urandom};
         b_all     = {$urandom, $urandom};
         out_ready = pat[cyc % 4];
         @(negedge clk);
         acc = ir[1];
         @(posedge clk); #1;
         if (acc) sent++;
         cyc++;
      end
      chk("bp_sent", 64'(sent), 64'd8);
      in_valid = 1'b0;
      repeat (40) begin
         out_ready = pat[cyc % 4];
         cyc++;
         @(posedge clk); #1;
      end
      rx_en = 1'b0;
      chk("bp_rx_count", 64'(rx_tags.size()), 64'd8);
      for (int i = 0; i < rx_tags.size() && i < 8; i++) begin
         chk($sformatf("bp_rx_order%0d", i), 64'(rx_tags[i]), 64'(i));
      end

      // Random soak.
      for (int i = 0; i < 10000; i++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         a_all    = {$urandom, $urandom};
         b_all    = ($urandom_range(0, 7) == 0) ? a_all : {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) b_all[63:4] = a_all[63:4];
         sm        = 1'($urandom_range(0, 1));
         tag       = 4'($urandom_range(0, 15));
         out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/mag_cmp_pipe.md
# mag_cmp_pipe

Parametrised, pipelined magnitude comparator producing greater-than, equal and less-than flags for two WIDTH-bit operands. Operands are split into 4-bit groups, each compared by a slice. The group results are reduced in a radix-4 registered tree. The block sits on streaming datapaths behind a valid/ready handshake, carries a user tag alongside each comparison, and stalls the whole pipe under backpressure.

## Interface
Parameters:
- WIDTH, 16: operand width in bits. Must be a multiple of 4, in the range 4..64.
- TAG_W, 4: width of the pass-through tag. Minimum 1.

Ports:
- clk  in  1  single clock; all registers are on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  the input operands are valid.
- in_ready  out  1  the block accepts input this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- in_tag  in  TAG_W  tag that travels with the operand pair.
- signed_mode  in  1  compare as two's complement. Present only when MAG_CMP_SIGNED_EN is defined.
- out_valid  out  1  the result is valid.
- out_ready  in  1  downstream accepts the result.
- gt  out  1  a > b.
- eq  out  1  a == b.
- lt  out  1  a < b.
- out_tag  out  TAG_W  the tag of the result currently presented.

## Operation
- Groups: G = WIDTH/4. Group g covers bits [4g+3:4g]. Group G-1 is the most significant.
- Slice: each group produces a gt flag and an eq flag for its 4 bits.
  - gt is evaluated MSB-first: it is set at the first bit position, from the top, where a=1 and b=0 while all higher bits in the group are equal.
  - eq is set when all 4 bits are equal.
- Reduction node: combines up to 4 (gt, eq) pairs, ordered from most to least significant.
  - gt = gt3 | eq3&gt2 | eq3&eq2&gt1 | eq3&eq2&eq1&gt0.
  - eq = AND of all eq inputs.
  - Missing inputs, when the group count is not a power of 4, are padded at the least-significant positions with gt=0, eq=1.
- Final output: lt = ~gt & ~eq. Exactly one of gt, eq, lt is 1 whenever out_valid=1.
- Signed mode: when it is active, bit WIDTH-1 of both a and b is inverted before slicing. No other change is made.
- Pipeline:
  - Stage 0 registers the slice outputs.
  - Each further stage registers one reduction level.
  - Valid and tag bits travel in lockstep with the data.
- Handshake:
  - adv = ~out_valid | out_ready.
  - in_ready = adv.
  - When adv=1, every stage shifts forward. Stage 0 loads in_valid & in_ready together with the operands.
  - When adv=0, every stage holds, and out_* stay stable.
  - Bubbles are not compressed. Throughput is 1 result per cycle whenever out_ready=1.
  - A transfer occurs on an input or output only when valid and ready are both 1.
- Reset:
  - All valid bits are cleared.
  - out_valid=0, gt=0, eq=0, lt=0, out_tag=0.
  - in_ready=1 in the cycle after reset.
  - Reset during operation discards every in-flight comparison, with no partial outputs.
  - Data registers other than the output flags and out_tag need not be reset.

## Timing
- Latency L = 1 + ceil(log4(G)) cycles from the input transfer to out_valid, with out_ready held at 1.
  - WIDTH=4: L=1.
  - WIDTH=16: L=2.
  - WIDTH=32 or 64: L=3.
- in_ready depends combinationally on out_ready and out_valid. There is no combinational path from a or b to any output.
- Simultaneous input and output transfers in the same cycle are legal. Back-to-back inputs are accepted every cycle while adv=1.
- signed_mode is sampled with a and b in the cycle of the input transfer.

## Configuration
- MAG_CMP_SIGNED_EN, defined: the signed_mode port exists and behaves as described under Operation.
- MAG_CMP_SIGNED_EN, undefined: the port is absent and every comparison is unsigned. No MSB inversion logic is present.

## Structure
Package mag_cmp_pkg holds:
- typedef cmp_res_t, a struct with fields gt and eq.
- Constant GROUP_W = 4 and function num_groups(width).
- Function num_levels(groups) = ceil(log4(groups)).
- Function reduce4(cmp_res_t [3:0]), which implements the reduction node.

Sub-module:
- cmp4_slice: a combinational 4-bit (gt, eq) comparator, instantiated G times.
- The reduction tree and the pipeline registers live in mag_cmp_pipe, built with generate loops.

## Test plan
- Basic unsigned, WIDTH=16, out_ready=1: a=0x1234, b=0x1233, tag=3. After 2 cycles, out_valid=1, gt=1, eq=0, lt=0, out_tag=3.
- Equality and per-group boundary: a=b=0xFFFF gives eq=1. Then a=0x8000, b=0x7FFF gives gt=1 unsigned. With the same operands and signed_mode=1 (macro defined), lt=1.
- Backpressure: stream tags 0..7 with out_ready toggling 1,0,0,1. Every tag appears in order exactly once. out_* are stable while out_ready=0, and in_ready tracks ~out_valid | out_ready.
- Padding with WIDTH=20 (G=5, L=3): a=0x80000, b=0x7FFFF gives gt=1. a=0x00001, b=0x00002 gives lt=1. Both results arrive 3 cycles after acceptance.
- Reset mid-stream: assert reset with 2 comparisons in flight. The next cycle shows out_valid=0 and flags=0. No stale result appears afterwards.
- Random soak: 10k random a, b, and signed_mode pairs at WIDTH=4, 16 and 64, with random out_ready. Results match a reference model and exactly one of gt, eq, lt is set.
